// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, word-address width, default NOP.
package pipe_pkg;

   localparam int unsigned WORD_AW = 32;
   localparam int unsigned INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_FETCH = 2'd1,
      ST_DROP  = 2'd2,
      ST_HOLD  = 2'd3
   } if_state_e;

   typedef struct packed {
      logic [WORD_AW-1:0] pc;
      logic [INSTR_W-1:0] instr;
   } fetch_word_t;

   // Sequential successor of a word address, wrapping modulo 2^WORD_AW.
   function automatic logic [WORD_AW-1:0] pc_next(input logic [WORD_AW-1:0] pc);
      return pc + WORD_AW'(1);
   endfunction

endpackage

// File: rtl/if_skid_reg.sv
// One-entry PC+instruction holding register used while IF/ID is stalled.
module if_skid_reg
   import pipe_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               clr_i,
   input  logic [WORD_AW-1:0] pc_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic [WORD_AW-1:0] pc_o,
   output logic [INSTR_W-1:0] instr_o
);

   fetch_word_t entry_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_q <= '0;
      end else if (clr_i) begin
         entry_q <= '0;
      end else if (load_i) begin
         entry_q <= '{pc: pc_i, instr: instr_i};
      end
   end

   assign pc_o    = entry_q.pc;
   assign instr_o = entry_q.instr;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch: PC, req/ack fetch FSM with redirect/drop handling, IF/ID register.
module ifetch_stage
   import pipe_pkg::*;
#(
   parameter logic [WORD_AW-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               Stall,
   input  logic               BranchTaken,
   input  logic [WORD_AW-1:0] BranchAddress,
   output logic               IMemReq,
   output logic [WORD_AW-1:0] IMemAddr,
   input  logic               IMemAck,
   input  logic [INSTR_W-1:0] IMemData,
   output logic [WORD_AW-1:0] IFID_PC,
   output logic [INSTR_W-1:0] IFID_Instr,
   output logic               IFID_Valid
);

   if_state_e          state_q, state_d;
   logic               req_q, req_d;
   logic [WORD_AW-1:0] pc_q, pc_d;
   logic [WORD_AW-1:0] pend_q, pend_d;
   logic [WORD_AW-1:0] ifid_pc_q, ifid_pc_d;
   logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
   logic               ifid_valid_q, ifid_valid_d;
   logic               skid_load, skid_clr;
   logic [WORD_AW-1:0] skid_pc;
   logic [INSTR_W-1:0] skid_instr;

   if_skid_reg u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (skid_load),
      .clr_i   (skid_clr),
      .pc_i    (pc_q),
      .instr_i (IMemData),
      .pc_o    (skid_pc),
      .instr_o (skid_instr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RST;
         req_q        <= 1'b0;
         pc_q         <= RESET_PC;
         pend_q       <= RESET_PC;
         ifid_pc_q    <= '0;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         pc_q         <= pc_d;
         pend_q       <= pend_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   // Next-state logic; BranchTaken is checked first in every state so it overrides Stall.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_d       = pend_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      skid_load    = 1'b0;
      skid_clr     = 1'b0;

      if (BranchTaken) begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP_INSTR;
      end

      unique case (state_q)
         ST_RST: begin
            state_d = ST_FETCH;
            if (BranchTaken) pc_d = BranchAddress;
         end
         ST_FETCH: begin
            if (BranchTaken) begin
               if (IMemAck) begin
                  pc_d = BranchAddress;
               end else begin
                  pend_d  = BranchAddress;
                  state_d = ST_DROP;
               end
            end else if (IMemAck) begin
               pc_d = pc_next(pc_q);
               if (Stall) begin
                  skid_load = 1'b1;
                  state_d   = ST_HOLD;
               end else begin
                  ifid_pc_d    = pc_q;
                  ifid_instr_d = IMemData;
                  ifid_valid_d = 1'b1;
               end
            end
         end
         ST_DROP: begin
            // The returning data belongs to the abandoned address and is never used.
            if (IMemAck) begin
               pc_d    = BranchTaken ? BranchAddress : pend_q;
               state_d = ST_FETCH;
            end else if (BranchTaken) begin
               pend_d = BranchAddress;
            end
         end
         ST_HOLD: begin
            if (BranchTaken) begin
               skid_clr = 1'b1;
               pc_d     = BranchAddress;
               state_d  = ST_FETCH;
            end else if (!Stall) begin
               ifid_pc_d    = skid_pc;
               ifid_instr_d = skid_instr;
               ifid_valid_d = 1'b1;
               skid_clr     = 1'b1;
               state_d      = ST_FETCH;
            end
         end
         default: state_d = ST_RST;
      endcase

      req_d = (state_d == ST_FETCH) || (state_d == ST_DROP);
   end

   assign IMemReq    = req_q;
   assign IMemAddr   = pc_q;
   assign IFID_PC    = ifid_pc_q;
   assign IFID_Instr = ifid_instr_q;
   assign IFID_Valid = ifid_valid_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed self-checking bench for ifetch_stage with hand-computed expectations.
module tb_ifetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Stall;
   logic        BranchTaken;
   logic [31:0] BranchAddress;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck;
   logic [31:0] IMemData;
   logic [31:0] IFID_PC;
   logic [31:0] IFID_Instr;
   logic        IFID_Valid;

   int n_tests = 0;
   int n_fail  = 0;

   ifetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .Stall         (Stall),
      .BranchTaken   (BranchTaken),
      .BranchAddress (BranchAddress),
      .IMemReq       (IMemReq),
      .IMemAddr      (IMemAddr),
      .IMemAck       (IMemAck),
      .IMemData      (IMemData),
      .IFID_PC       (IFID_PC),
      .IFID_Instr    (IFID_Instr),
      .IFID_Valid    (IFID_Valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then return at the next falling edge.
   task automatic step(input logic ack, input logic stall, input logic bt, input logic [31:0] ba);
      IMemAck       = ack;
      Stall         = stall;
      BranchTaken   = bt;
      BranchAddress = ba;
      IMemData      = ack ? mem_word(IMemAddr) : 32'hBAD0_BAD0;
      @(posedge clk);
      @(negedge clk);
      IMemAck       = 1'b0;
      Stall         = 1'b0;
      BranchTaken   = 1'b0;
      BranchAddress = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      Stall = 1'b0;
      BranchTaken = 1'b0;
      BranchAddress = '0;
      IMemAck = 1'b0;
      IMemData = '0;
      @(negedge clk);
      check("rst_req",   32'(IMemReq), 32'd0);
      check("rst_addr",  IMemAddr, 32'h0);
      check("rst_ifpc",  IFID_PC, 32'h0);
      check("rst_instr", IFID_Instr, NOP);
      check("rst_valid", 32'(IFID_Valid), 32'd0);

      rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check("first_req",   32'(IMemReq), 32'd1);
      check("first_addr",  IMemAddr, 32'h0);
      check("first_valid", 32'(IFID_Valid), 32'd0);

      // Back-to-back acks at addresses 0..4.
      for (int k = 0; k < 5; k++) begin
         check("seq_addr", IMemAddr, 32'(k));
         step(1'b1, 1'b0, 1'b0, 32'h0);
         check("seq_ifpc",  IFID_PC, 32'(k));
         check("seq_instr", IFID_Instr, mem_word(32'(k)));
         check("seq_valid", 32'(IFID_Valid), 32'd1);
      end

      // Stall with ack at PC=5, held for three cycles.
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("hold_req",  32'(IMemReq), 32'd0);
      check("hold_ifpc", IFID_PC, 32'h4);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("hold3_req",   32'(IMemReq), 32'd0);
      check("hold3_ifpc",  IFID_PC, 32'h4);
      check("hold3_instr", IFID_Instr, mem_word(32'h4));
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check("rel_ifpc",  IFID_PC, 32'h5);
      check("rel_instr", IFID_Instr, mem_word(32'h5));
      check("rel_valid", 32'(IFID_Valid), 32'd1);
      check("rel_req",   32'(IMemReq), 32'd1);
      check("rel_addr",  IMemAddr, 32'h6);

      // Redirect coinciding with ack at PC=7.
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("pc7_addr", IMemAddr, 32'h7);
      step(1'b1, 1'b0, 1'b1, 32'h40);
      check("bra_valid", 32'(IFID_Valid), 32'd0);
      check("bra_instr", IFID_Instr, NOP);
      check("bra_addr",  IMemAddr, 32'h40);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("tgt_ifpc",  IFID_PC, 32'h40);
      check("tgt_valid", 32'(IFID_Valid), 32'd1);
      check("tgt_addr",  IMemAddr, 32'h41);

      // Redirect while the fetch at 0x41 is still outstanding.
      step(1'b0, 1'b0, 1'b1, 32'h80);
      check("drop_addr",  IMemAddr, 32'h41);
      check("drop_req",   32'(IMemReq), 32'd1);
      check("drop_valid", 32'(IFID_Valid), 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check("drop_addr3", IMemAddr, 32'h41);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("drop_done_valid", 32'(IFID_Valid), 32'd0);
      check("drop_done_instr", IFID_Instr, NOP);
      check("drop_done_addr",  IMemAddr, 32'h80);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("t80_ifpc", IFID_PC, 32'h80);

      // Latest redirect during DROP wins.
      step(1'b0, 1'b0, 1'b1, 32'h90);
      step(1'b0, 1'b0, 1'b1, 32'hC0);
      check("drop2_addr", IMemAddr, 32'h81);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("latest_addr", IMemAddr, 32'hC0);

      // Ack and redirect coinciding in DROP.
      step(1'b0, 1'b0, 1'b1, 32'h200);
      step(1'b1, 1'b0, 1'b1, 32'h300);
      check("drop_ackbr_addr", IMemAddr, 32'h300);

      // Wrap from the top of the address space.
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
      check("wrap_pre", IMemAddr, 32'hFFFF_FFFF);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("wrap_ifpc", IFID_PC, 32'hFFFF_FFFF);
      check("wrap_addr", IMemAddr, 32'h0);

      // Redirect in HOLD overrides Stall and discards the skid.
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("hold2_req", 32'(IMemReq), 32'd0);
      step(1'b0, 1'b1, 1'b1, 32'h500);
      check("hbr_valid", 32'(IFID_Valid), 32'd0);
      check("hbr_instr", IFID_Instr, NOP);
      check("hbr_req",   32'(IMemReq), 32'd1);
      check("hbr_addr",  IMemAddr, 32'h500);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("hbr_ifpc", IFID_PC, 32'h500);

      // Asynchronous reset mid-request.
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_req",   32'(IMemReq), 32'd0);
      check("arst_addr",  IMemAddr, 32'h0);
      check("arst_ifpc",  IFID_PC, 32'h0);
      check("arst_instr", IFID_Instr, NOP);
      check("arst_valid", 32'(IFID_Valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage: owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register (PC, instruction, valid). It sits at the front of the pipeline. It consumes the redirect target computed in EX from `IDEX_PC` plus the sign-extended branch or jump offset. Supports stall, redirect-with-flush, and redirects that arrive while a memory request is outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0000: value driven on `IFID_Instr` on reset and on flush.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Stall` in 1: hazard unit request to hold IF/ID.
- `BranchTaken` in 1: EX redirect strobe. Valid for one cycle.
- `BranchAddress` in 32: redirect target (EX branch/jump adder result).
- `IMemReq` out 1: fetch request.
- `IMemAddr` out 32: word address of the fetch.
- `IMemAck` in 1: memory completion. Sampled on the rising edge while `IMemReq`=1.
- `IMemData` in 32: instruction. Valid in the ack cycle.
- `IFID_PC` out 32: PC of the instruction held in IF/ID.
- `IFID_Instr` out 32: instruction held in IF/ID.
- `IFID_Valid` out 1: IF/ID holds a live instruction.

## Operation
- PC is a word address. The sequential successor is PC+1, wrapping modulo 2^32 (32'hFFFF_FFFF → 0).
- States:
  - RST: entered on reset; no request.
  - FETCH: `IMemReq`=1, `IMemAddr`=PC.
  - DROP: `IMemReq`=1, `IMemAddr`=PC (old address). Completes an abandoned request.
  - HOLD: `IMemReq`=0. Skid register full.
- Registers:
  - PC
  - PendPC (redirect target saved during DROP)
  - SkidPC/SkidInstr
  - IF/ID triple
  - state
- RST → FETCH unconditionally on the first clock after reset release.
- FETCH, ack and no BranchTaken:
  - `Stall`=0: IF/ID ← {PC, IMemData, 1}; PC ← PC+1; stay in FETCH.
  - `Stall`=1: Skid ← {PC, IMemData}; PC ← PC+1; go to HOLD.
- FETCH, no ack and no BranchTaken: hold all registers. `IMemAddr` stays stable until ack.
- BranchTaken in FETCH:
  - With ack in the same cycle: discard IMemData; PC ← BranchAddress; stay in FETCH.
  - Without ack: PendPC ← BranchAddress; go to DROP.
  - Either way, flush IF/ID (Valid ← 0, Instr ← NOP_INSTR).
- DROP:
  - On ack: discard data; PC ← PendPC; go to FETCH.
  - BranchTaken while in DROP: PendPC ← BranchAddress (latest redirect wins).
  - If ack and BranchTaken coincide: PC ← BranchAddress.
  - IF/ID stays flushed.
- HOLD:
  - BranchTaken: discard skid; flush IF/ID; PC ← BranchAddress; go to FETCH.
  - Else if `Stall`=0: IF/ID ← {SkidPC, SkidInstr, 1}; go to FETCH.
  - Else: hold.
- Priority: BranchTaken overrides Stall in every state. A flush clears IF/ID even when `Stall`=1.
- `Stall` freezes the IF/ID contents regardless of `IFID_Valid`.
- Reset mid-request: the abandoned request is not tracked. Memory must drop any outstanding request when `rst_n` is asserted.

## Timing
- Reset values:
  - `IMemReq`=0
  - `IMemAddr`=RESET_PC
  - `IFID_PC`=0
  - `IFID_Instr`=NOP_INSTR
  - `IFID_Valid`=0
  - PC=RESET_PC
  - state RST
- `IMemReq`/`IMemAddr` are decoded from registered state and PC only. There is no combinational path from `IMemAck`, `Stall`, or `BranchTaken` to memory outputs.
- First request: the cycle after reset release. First `IFID_Valid`=1 is visible the cycle after the first ack edge.
- Throughput: one instruction per cycle when `IMemAck`=1 every cycle with `Stall`=0.
- Redirect penalty with zero-wait memory:
  - BranchTaken cycle N: IF/ID flushed at edge N.
  - Target fetch issued in cycle N+1.
  - Target valid in IF/ID after the edge ending N+1.
- IF/ID outputs change only on clock edges.

## Structure
- Shared package `pipe_pkg`: state encoding (RST, FETCH, DROP, HOLD), `NOP_INSTR` default, word-address width constant.
- One natural sub-module, `if_skid_reg`: a 1-entry PC+instruction holding register with load/clear.
- The FSM, PC, and IF/ID register stay in `ifetch_stage`.

## Test plan
- Reset then `IMemAck`=1 every cycle, `Stall`=0 → `IMemAddr` 0,1,2,3 on consecutive cycles; `IFID_PC` 0,1,2 each with `IFID_Valid`=1.
- Ack with `Stall`=1 for 3 cycles at PC=5 → state HOLD, `IMemReq`=0, IF/ID still shows PC 4. After release, `IFID_PC`=5 and the next request is at 6.
- `BranchTaken`, `BranchAddress`=32'h40, same cycle as ack at PC=7 → data discarded, `IFID_Valid`=0, next `IMemAddr`=32'h40.
- `BranchTaken` to 32'h80 while waiting (ack delayed 3 cycles) → `IMemAddr` held at the old PC until ack; returned data never reaches IF/ID; then `IMemAddr`=32'h80.
- Second `BranchTaken` to 32'hC0 during DROP → fetch resumes at 32'hC0, not 32'h80.
- PC=32'hFFFF_FFFF fetched → next `IMemAddr`=0; `rst_n` dropped mid-request → outputs at reset values immediately.
